// File: rtl/operand_streamer.sv
// operand_streamer: unpacks a 512-bit line into (a, b) operand pairs, one pair per cycle.
// Optional macro OPERAND_STREAMER_DBUF_EN adds a second line slot for bubble-free streaming.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | slot0 empty, waiting for a line
// STREAM | slot0 holds a line, idx selects the pair on op_a/op_b

module operand_streamer #(
    parameter  int DATA_LEN = 32,
    localparam int PAIRS    = 512 / (2 * DATA_LEN),
    localparam int IDX_W    = (PAIRS > 1) ? $clog2(PAIRS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic                line_valid,
    output logic                line_ready,
    input  logic [511:0]        line_data,
    output logic                op_valid,
    input  logic                op_ready,
    output logic [DATA_LEN-1:0] op_a,
    output logic [DATA_LEN-1:0] op_b,
    output logic [IDX_W-1:0]    op_idx,
    output logic                op_last,
    output logic [15:0]         lines_done,
    output logic                busy
);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    // pair i occupies [i][0] = a, [i][1] = b, matching the host line layout
    typedef logic [PAIRS-1:0][1:0][DATA_LEN-1:0] line_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    line_t            slot0_q;
    logic             out_of_reset_q;

    logic line_xfer;
    logic pair_xfer;
    logic last_pair;
    logic ld0_line;
    logic done_inc;
    logic slot1_full;

`ifdef OPERAND_STREAMER_DBUF_EN
    line_t slot1_q;
    logic  slot1_full_q, slot1_full_d;
    logic  ld0_slot1;
    logic  ld1;

    assign slot1_full = slot1_full_q;
    assign line_ready = out_of_reset_q && !slot1_full_q && !flush;
`else
    assign slot1_full = 1'b0;
    assign line_ready = out_of_reset_q && (state_q == IDLE) && !flush;
`endif

    assign op_valid  = (state_q == STREAM);
    assign op_a      = slot0_q[idx_q][0];
    assign op_b      = slot0_q[idx_q][1];
    assign op_idx    = idx_q;
    assign last_pair = (idx_q == IDX_W'(PAIRS - 1));
    assign op_last   = op_valid && last_pair;
    assign busy      = (state_q == STREAM) || slot1_full;

    assign line_xfer = line_valid && line_ready;
    assign pair_xfer = op_valid && op_ready;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        ld0_line     = 1'b0;
        done_inc     = 1'b0;
`ifdef OPERAND_STREAMER_DBUF_EN
        ld0_slot1    = 1'b0;
        ld1          = 1'b0;
        slot1_full_d = slot1_full_q;
`endif
        if (flush) begin
            state_d = IDLE;
            idx_d   = '0;
`ifdef OPERAND_STREAMER_DBUF_EN
            slot1_full_d = 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (line_xfer) begin
                        ld0_line = 1'b1;
                        idx_d    = '0;
                        state_d  = STREAM;
                    end
                end
                STREAM: begin
                    if (pair_xfer && !last_pair) begin
                        idx_d = idx_q + 1'b1;
                    end else if (pair_xfer) begin
                        done_inc = 1'b1;
                        idx_d    = '0;
`ifdef OPERAND_STREAMER_DBUF_EN
                        // refill slot0 from slot1 first, else straight from the bus
                        if (slot1_full_q) begin
                            ld0_slot1    = 1'b1;
                            slot1_full_d = 1'b0;
                        end else if (line_xfer) begin
                            ld0_line = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
`else
                        state_d = IDLE;
`endif
                    end
`ifdef OPERAND_STREAMER_DBUF_EN
                    if (line_xfer && !(pair_xfer && last_pair)) begin
                        ld1          = 1'b1;
                        slot1_full_d = 1'b1;
                    end
`endif
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            idx_q          <= '0;
            slot0_q        <= '0;
            lines_done     <= '0;
            out_of_reset_q <= 1'b0;
`ifdef OPERAND_STREAMER_DBUF_EN
            slot1_q        <= '0;
            slot1_full_q   <= 1'b0;
`endif
        end else begin
            out_of_reset_q <= 1'b1;
            state_q        <= state_d;
            idx_q          <= idx_d;
            if (ld0_line)
                slot0_q <= line_data;
`ifdef OPERAND_STREAMER_DBUF_EN
            else if (ld0_slot1)
                slot0_q <= slot1_q;
            if (ld1)
                slot1_q <= line_data;
            slot1_full_q <= slot1_full_d;
`endif
            if (done_inc)
                lines_done <= lines_done + 16'd1;
        end
    end

endmodule

// File: tb/tb_operand_streamer.sv
// Self-checking bench for operand_streamer: a queue of outstanding pairs is the reference,
// compared against the DUT every cycle, plus directed literal checks per scenario.

module tb_operand_streamer;

    localparam int DATA_LEN = 32;
    localparam int PAIRS    = 512 / (2 * DATA_LEN);
    localparam int IDX_W    = $clog2(PAIRS);

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic                flush = 1'b0;
    logic                line_valid = 1'b0;
    logic                line_ready;
    logic [511:0]        line_data = '0;
    logic                op_valid;
    logic                op_ready = 1'b0;
    logic [DATA_LEN-1:0] op_a;
    logic [DATA_LEN-1:0] op_b;
    logic [IDX_W-1:0]    op_idx;
    logic                op_last;
    logic [15:0]         lines_done;
    logic                busy;

    operand_streamer #(.DATA_LEN(DATA_LEN)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .line_valid (line_valid),
        .line_ready (line_ready),
        .line_data  (line_data),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .op_a       (op_a),
        .op_b       (op_b),
        .op_idx     (op_idx),
        .op_last    (op_last),
        .lines_done (lines_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_LEN-1:0] a;
        logic [DATA_LEN-1:0] b;
        logic [IDX_W-1:0]    idx;
        logic                last;
    } pair_t;

    pair_t        exp_q[$];
    bit           oor_m = 1'b0;
    logic [15:0]  ld_cnt = '0;
    logic [15:0]  ld_bias = '0;
    bit           s_line = 1'b0;
    bit           s_pair = 1'b0;
    bit           s_flush = 1'b0;
    logic [511:0] s_data = '0;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // reference: every accepted line appends its PAIRS pairs; every pair handshake pops one
    always @(posedge clk or negedge reset) begin
        pair_t p;
        if (!reset) begin
            exp_q.delete();
            oor_m  = 1'b0;
            ld_cnt = '0;
        end else begin
            oor_m = 1'b1;
            if (s_flush) begin
                exp_q.delete();
            end else begin
                if (s_pair && exp_q.size() != 0) begin
                    p = exp_q.pop_front();
                    if (p.last) ld_cnt = ld_cnt + 16'd1;
                end
                if (s_line) begin
                    for (int i = 0; i < PAIRS; i++) begin
                        p.a    = s_data[2*i*DATA_LEN +: DATA_LEN];
                        p.b    = s_data[(2*i+1)*DATA_LEN +: DATA_LEN];
                        p.idx  = IDX_W'(i);
                        p.last = (i == PAIRS - 1);
                        exp_q.push_back(p);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        pair_t       f;
        logic        ev;
        logic        elr;
        logic [15:0] eld;
        ev  = (exp_q.size() != 0);
`ifdef OPERAND_STREAMER_DBUF_EN
        elr = oor_m && (exp_q.size() <= PAIRS) && !flush;
`else
        elr = oor_m && (exp_q.size() == 0) && !flush;
`endif
        eld = ld_cnt + ld_bias;
        chk("op_valid", op_valid, ev);
        chk("busy", busy, ev);
        chk("line_ready", line_ready, elr);
        chk("lines_done", lines_done, eld);
        if (ev) begin
            f = exp_q[0];
            chk("op_a", op_a, f.a);
            chk("op_b", op_b, f.b);
            chk("op_idx", op_idx, f.idx);
            chk("op_last", op_last, f.last);
        end
        s_line  = line_valid && line_ready;
        s_pair  = op_valid && op_ready;
        s_flush = flush;
        s_data  = line_data;
    end

    function automatic logic [511:0] mk_line(input logic [31:0] abase, input logic [31:0] bbase);
        logic [511:0] l;
        l = '0;
        for (int i = 0; i < PAIRS; i++) begin
            l[2*i*DATA_LEN +: DATA_LEN]     = DATA_LEN'(abase + 32'(i));
            l[(2*i+1)*DATA_LEN +: DATA_LEN] = DATA_LEN'(bbase + 32'(i));
        end
        return l;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_line(input logic [511:0] d, input bit keep, input string tag);
        bit ok;
        ok         = 1'b0;
        line_data  = d;
        line_valid = 1'b1;
        for (int c = 0; c < 64 && !ok; c++) begin
            @(negedge clk);
            ok = line_ready;
            step();
        end
        if (!keep) line_valid = 1'b0;
        chk({tag, "_accepted"}, ok, 1'b1);
    endtask

    task automatic wait_xfers(input int n, input int budget, input logic [3:0] pat,
                              output int got, output int span, output int gaps);
        int k;
        got = 0; span = 0; gaps = 0; k = 0;
        while (got < n && k < budget) begin
            op_ready = pat[k % 4];
            @(negedge clk);
            if (op_valid && op_ready) begin
                got++;
                span++;
            end else if (got > 0) begin
                span++;
                if (!op_valid) gaps++;
            end
            k++;
            step();
        end
    endtask

    int got, span, gaps;
    logic [511:0] ld_line;

    initial begin
        // reset values, then release between edges
        repeat (2) step();
        #2;
        chk("rst_op_valid", op_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_line_ready", line_ready, 1'b0);
        chk("rst_lines_done", lines_done, 16'h0);
        chk("rst_op_last", op_last, 1'b0);
        reset = 1'b1;
        #1 chk("ready_before_edge", line_ready, 1'b0);
        step();
        #3 chk("ready_after_edge", line_ready, 1'b1);

        // single line, op_ready held
        op_ready = 1'b1;
        send_line(mk_line(32'd1, 32'h100), 1'b0, "line1");
        #3;
        chk("l1_valid", op_valid, 1'b1);
        chk("l1_idx0", op_idx, 0);
        chk("l1_a0", op_a, 32'h1);
        chk("l1_b0", op_b, 32'h100);
        chk("l1_last0", op_last, 1'b0);
        wait_xfers(8, 30, 4'b1111, got, span, gaps);
        chk("l1_xfers", got, 8);
        chk("l1_span", span, 8);
        #3;
        chk("l1_done", lines_done, 16'd1);
        chk("l1_busy", busy, 1'b0);

        // op_ready pattern 1,0,0,1
        send_line(mk_line(32'h1234_0000, 32'h5678_0000), 1'b0, "line2");
        wait_xfers(8, 40, 4'b1001, got, span, gaps);
        chk("l2_xfers", got, 8);
        chk("l2_span", span, 16);
        chk("l2_gaps", gaps, 0);
        #3 chk("l2_done", lines_done, 16'd2);

        // back-to-back lines with line_valid held
        op_ready = 1'b1;
        fork
            begin
                send_line(mk_line(32'hAAAA_0000, 32'hAAAA_1000), 1'b1, "lineA");
                send_line(mk_line(32'hBBBB_0000, 32'hBBBB_1000), 1'b0, "lineB");
            end
            wait_xfers(16, 60, 4'b1111, got, span, gaps);
        join
        chk("ab_xfers", got, 16);
`ifdef OPERAND_STREAMER_DBUF_EN
        chk("ab_span", span, 16);
        chk("ab_gaps", gaps, 0);
`else
        chk("ab_span", span, 17);
        chk("ab_gaps", gaps, 1);
`endif
        #3 chk("ab_done", lines_done, 16'd4);

        // flush after the third pair, with a line waiting
        fork
            send_line(mk_line(32'hC000_0000, 32'hC000_1000), 1'b0, "lineC");
            wait_xfers(3, 30, 4'b1111, got, span, gaps);
        join
        chk("c_xfers", got, 3);
        ld_line    = mk_line(32'hD000_0000, 32'hD000_1000);
        op_ready   = 1'b0;
        flush      = 1'b1;
        line_valid = 1'b1;
        line_data  = ld_line;
        #3;
        chk("flush_ready", line_ready, 1'b0);
        chk("flush_idx", op_idx, 3);
        step();
        flush = 1'b0;
        #3;
        chk("post_flush_valid", op_valid, 1'b0);
        chk("post_flush_busy", busy, 1'b0);
        chk("post_flush_ready", line_ready, 1'b1);
        chk("post_flush_done", lines_done, 16'd4);
        step();
        line_valid = 1'b0;
        #3;
        chk("d_valid", op_valid, 1'b1);
        chk("d_idx0", op_idx, 0);
        chk("d_a0", op_a, 32'hD000_0000);
        wait_xfers(8, 30, 4'b1111, got, span, gaps);
        chk("d_xfers", got, 8);
        #3 chk("d_done", lines_done, 16'd5);

        // asynchronous reset mid-line
        fork
            send_line(mk_line(32'hE000_0000, 32'hE000_1000), 1'b0, "lineE");
            wait_xfers(2, 30, 4'b1111, got, span, gaps);
        join
        #2 reset = 1'b0;
        #1;
        chk("async_op_valid", op_valid, 1'b0);
        chk("async_busy", busy, 1'b0);
        chk("async_done", lines_done, 16'h0);
        chk("async_ready", line_ready, 1'b0);
        step();
        step();
        #2 reset = 1'b1;
        #1 chk("rel_ready_before_edge", line_ready, 1'b0);
        step();
        #3 chk("rel_ready_after_edge", line_ready, 1'b1);
        fork
            send_line(mk_line(32'hF000_0000, 32'hF000_1000), 1'b0, "lineF");
            wait_xfers(8, 30, 4'b1111, got, span, gaps);
        join
        chk("f_xfers", got, 8);
        #3 chk("f_done", lines_done, 16'd1);

        // lines_done wrap: preload near the top instead of draining 65534 lines
        step();
        force dut.lines_done = 16'hFFFE;
        ld_bias = 16'hFFFE - ld_cnt;
        #1 release dut.lines_done;
        #2 chk("preload", lines_done, 16'hFFFE);
        fork
            send_line(mk_line(32'h0101_0000, 32'h0202_0000), 1'b0, "lineG");
            wait_xfers(8, 30, 4'b1111, got, span, gaps);
        join
        #3 chk("done_ffff", lines_done, 16'hFFFF);
        fork
            send_line(mk_line(32'h0303_0000, 32'h0404_0000), 1'b0, "lineH");
            wait_xfers(8, 30, 4'b1111, got, span, gaps);
        join
        #3;
        chk("done_wrap", lines_done, 16'h0000);
        chk("wrap_busy", busy, 1'b0);

        repeat (3) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/operand_streamer.md
# operand_streamer

Upstream operand-feed stage for the arithmetic DUT harness. It accepts one 512-bit cache line returned from the host input buffer and unpacks it into consecutive (a, b) operand pairs. It issues one pair per cycle over a valid/ready handshake to the DUT-side state machine. This replaces the single-pair-per-line scheme, so one host read feeds a whole pipelined multiplier or divider burst.

## Interface
Parameters:
- DATA_LEN, 32, operand width; must be one of 8/16/32/64/128/256.
- PAIRS (localparam), 512/(2*DATA_LEN), pairs per line (8 at default).
- IDX_W (localparam), $clog2(PAIRS), pair index width.

Ports:
- clk  in  1  sole clock; all logic on posedge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous discard of all buffered data.
- line_valid  in  1  line_data is valid.
- line_ready  out  1  block can accept a line.
- line_data  in  512  pair i: a = bits [2i*DATA_LEN +: DATA_LEN], b = bits [(2i+1)*DATA_LEN +: DATA_LEN].
- op_valid  out  1  op_a/op_b/op_idx/op_last valid.
- op_ready  in  1  consumer accepts the current pair.
- op_a  out  DATA_LEN  operand a.
- op_b  out  DATA_LEN  operand b.
- op_idx  out  IDX_W  pair index within the line.
- op_last  out  1  high with pair PAIRS-1.
- lines_done  out  16  count of fully drained lines; wraps 0xFFFF -> 0.
- busy  out  1  any line is buffered.

## Operation
- States: IDLE (slot0 empty) and STREAM (slot0 holds a line; idx points at the current pair).
- A line transfer occurs on line_valid && line_ready. A pair transfer occurs on op_valid && op_ready.
- IDLE with a line transfer: load slot0, set idx=0, go to STREAM.
- STREAM: op_valid=1. op_a/op_b are muxed from slot0 by idx. op_last=(idx==PAIRS-1).
- A pair transfer with idx<PAIRS-1 increments idx.
- A pair transfer with idx==PAIRS-1 increments lines_done. The next state is then set by the configuration (below).
- While op_valid && !op_ready, op_a, op_b, op_idx and op_last hold stable. op_valid never drops without a transfer, except on flush or reset.
- flush=1 at an edge clears all slots, sets idx=0 and goes to IDLE; op_valid is 0 the next cycle.
  - While flush is high, line_ready is forced to 0, so a line is never accepted on a flush edge.
  - flush does not change lines_done.
- busy = (state==STREAM) || slot1 full.

## Timing
- Reset values while reset is low: state IDLE, idx 0, op_valid 0, op_last 0, busy 0, lines_done 0, slots empty. line_ready is 0 while reset is low.
- A registered out_of_reset flag holds line_ready at 0 until the first edge after reset deassertion. line_ready is 1 from the following cycle.
- Latency: a line accepted at edge N presents pair 0 with op_valid=1 in the cycle after edge N.
- Throughput: 1 pair per cycle while op_ready=1. A line drains in PAIRS cycles minimum.
- Reset asserted mid-stream: all outputs go to their reset values immediately (asynchronous). The partial line is lost and is not counted.

## Configuration
- Macro: OPERAND_STREAMER_DBUF_EN.
- Undefined (single buffer):
  - line_ready = out_of_reset && (state==IDLE) && !flush.
  - After the last pair transfer, the block goes to IDLE.
  - This gives one bubble cycle between lines.
- Defined (double buffer):
  - A second slot (slot1) is added. line_ready = out_of_reset && !slot1_full && !flush.
  - A line accepted while in STREAM goes to slot1.
  - On the last pair transfer with slot1 full: slot1 moves to slot0, idx=0, and the block stays in STREAM. There is no bubble.
  - On the last pair transfer with slot1 empty and a simultaneous line transfer: the line loads directly into slot0, idx=0, and the block stays in STREAM.
  - On the last pair transfer with slot1 empty and no line transfer: the block goes to IDLE.

## Test plan
- Reset release, then one line with a_i=i+1 and b_i=0x100+i, and op_ready held at 1 -> pairs 0..7 appear on 8 consecutive cycles with op_idx 0..7 and op_last only on idx 7. lines_done=1, busy=0 after.
- op_ready toggling 1,0,0,1 during a line -> outputs stay stable during stalls. No pair is lost or duplicated, and exactly 8 transfers occur.
- Two back-to-back lines (0xA-pattern, then 0xB-pattern) with line_valid held high -> without the macro, exactly one idle cycle (op_valid=0) between the lines. With OPERAND_STREAMER_DBUF_EN, 16 transfers on 16 consecutive cycles. lines_done=2.
- flush asserted after the 3rd pair while line_valid=1 -> line_ready=0 on that cycle and op_valid=0 the next cycle. A new line then restarts at op_idx=0. lines_done is unchanged.
- reset driven low asynchronously mid-line (between edges) -> op_valid and busy go to 0 immediately and lines_done=0. line_ready=0 until one edge after release.
- 65536 drained lines -> lines_done wraps to 0x0000.
